muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 35 +++
 rtl/muldiv_seq_step.sv | 27 ++
 rtl/muldiv_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared execute-stage types: functional-unit select, RV32M op encoding, mul/div FSM states.
package muldiv_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EX_ALU,
        EX_BRANCH,
        EX_LSU,
        EX_MULDIV
    } ex_func_e;

    // Encoding matches RV32M funct3, so op[2] selects divide and op[1] selects remainder.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } muldiv_state_e;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration: shift-add multiply (LSB first) or restoring shift-subtract divide.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   tmp;
    logic            ge;

    // Multiply: {hi,lo} holds partial product over the shrinking multiplier.
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign tmp = {hi, lo[XLEN-1]};
    assign ge  = tmp >= {1'b0, m};

    assign hi_nxt = is_div ? (ge ? (tmp[XLEN-1:0] - m) : tmp[XLEN-1:0]) : sum[XLEN:1];
    assign lo_nxt = is_div ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit; define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            n_rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    muldiv_state_e   state;
    logic [4:0]      cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi_q, lo_q, m_q;
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    logic            is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg, neg_res, div0, ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res, final_res, quo_s, rem_s;
    logic [63:0]     prod, prod_s;

    assign is_div  = op_i[2];
    assign is_rem  = op_i[1];
    assign a_sgn   = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
    assign b_sgn   = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
    assign a_neg   = a_sgn & operand_a_i[XLEN-1];
    assign b_neg   = b_sgn & operand_b_i[XLEN-1];
    assign a_mag   = mag(operand_a_i, a_neg);
    assign b_mag   = mag(operand_b_i, b_neg);
    // Remainder takes the dividend's sign; everything else takes the product of signs.
    assign neg_res = (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);

    assign div0 = is_div && (operand_b_i == '0);
    assign ovf  = is_div && b_sgn && (operand_a_i == 32'h8000_0000) && (operand_b_i == 32'hFFFF_FFFF);
    assign special_res = div0 ? (is_rem ? operand_a_i : 32'hFFFF_FFFF)
                              : (is_rem ? 32'h0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [65:0] fprod;
    logic [XLEN-1:0]    fast_res;
    assign fprod    = $signed({a_sgn & operand_a_i[XLEN-1], operand_a_i})
                    * $signed({b_sgn & operand_b_i[XLEN-1], operand_b_i});
    assign fast_res = (op_i == MD_MUL) ? fprod[31:0] : fprod[63:32];
`endif

    muldiv_step u_step (
        .is_div (op_q[2]),
        .hi     (hi_q),
        .lo     (lo_q),
        .m      (m_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    assign prod      = {hi_nxt, lo_nxt};
    assign prod_s    = neg_q ? -prod : prod;
    assign quo_s     = mag(lo_nxt, neg_q);
    assign rem_s     = mag(hi_nxt, neg_q);
    assign final_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                               : ((op_q == MD_MUL) ? prod_s[31:0] : prod_s[63:32]);

    assign stall_o = n_rst && (((state == MD_IDLE) && start_i && !flush_i) || (state == MD_BUSY));
    assign valid_o = (state == MD_DONE);
    assign busy_o  = (state != MD_IDLE);

    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            result_o <= '0;
        end else if (flush_i) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start_i) begin
                    op_q  <= op_i;
                    neg_q <= neg_res;
                    cnt   <= '0;
                    if (div0 || ovf) begin
                        result_o <= special_res;
                        state    <= MD_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        result_o <= fast_res;
                        state    <= MD_DONE;
                    end
`endif
                    else begin
                        hi_q  <= '0;
                        lo_q  <= is_div ? a_mag : b_mag;
                        m_q   <= is_div ? b_mag : a_mag;
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    if (cnt == 5'd31) begin
                        cnt      <= '0;
                        result_o <= final_res;
                        state    <= MD_DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule
